// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time the shared FIFO
// write port for bursts of up to BURST_LEN beats, with one idle cycle between grants.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_w_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic                            grant_valid,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id
);

  localparam int unsigned ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pick_found;
  logic [ID_W-1:0]   pick_id;

  // Index base+off reduced modulo NUM_REQ (both operands already below NUM_REQ).
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                               input int unsigned    off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return ID_W'(sum);
  endfunction

  // First valid requester searching upward from the round-robin pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!pick_found && req_valid[wrap_add(rr_q, i)]) begin
        pick_found = 1'b1;
        pick_id    = wrap_add(rr_q, i);
      end
    end
  end

  // Next-state and output decode; write path is combinational off the held grant.
  always_comb begin
    state_d      = state_q;
    gid_d        = gid_q;
    rr_d         = rr_q;
    cnt_d        = cnt_q;
    req_ready    = '0;
    fifo_w_en    = 1'b0;
    fifo_data_in = '0;
    grant_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = BURST;
          gid_d   = pick_id;
          cnt_d   = '0;
        end
      end
      BURST: begin
        grant_valid         = 1'b1;
        req_ready[gid_q]    = ~fifo_full;
        fifo_w_en           = req_valid[gid_q] & ~fifo_full;
        fifo_data_in        = req_data[32'(gid_q) * DATA_WIDTH +: DATA_WIDTH];
        if (fifo_w_en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Release on a dropped request or on the beat that completes the burst.
        if (!req_valid[gid_q] || (fifo_w_en && (cnt_q == CNT_W'(BURST_LEN - 1)))) begin
          state_d = IDLE;
          cnt_d   = '0;
          rr_d    = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, grant, pointer and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gid_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign grant_id = gid_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: behavioural arbiter model, per-requester source
// queues and a modelled shared FIFO whose readback is scoreboarded.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BL    = 4;
  localparam int DEPTH = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_w_en;
  logic [DW-1:0]   fifo_data_in;
  logic            grant_valid;
  logic [1:0]      grant_id;

  fifo_wr_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .BURST_LEN(BL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_w_en    (fifo_w_en),
    .fifo_data_in (fifo_data_in),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment
  logic [DW-1:0] rq [N][$];
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wr_log [$];
  int            g_ids [$];
  int            g_beats [$];
  int            g_gaps [$];
  logic          rst_val;
  logic          force_full;
  logic          rd_alt;
  logic          rd_en;
  logic          prev_gv;
  int            idle_cnt;
  int            cyc;

  // Reference model: current owner (-1 when none), beats taken, next search start
  int m_owner;
  int m_beats;
  int m_ptr;

  int n_chk;
  int n_err;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beats = 0;
    m_ptr   = 0;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    g_ids.delete();
    g_beats.delete();
    g_gaps.delete();
    idle_cnt = 0;
    prev_gv  = 1'b0;
  endtask

  task automatic clear_env();
    for (int i = 0; i < N; i++) rq[i].delete();
    fifo_q.delete();
    exp_q.delete();
    clear_logs();
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i] = (rq[i].size() > 0);
      req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0] : '0;
    end
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance
  // the model and the environment to what the coming posedge must do.
  task automatic cycle();
    logic         e_gv;
    logic         e_wen;
    logic [N-1:0] e_ready;
    logic [DW-1:0] e_data;
    logic [DW-1:0] got;
    @(negedge clk);
    rst_n = rst_val;
    drive_inputs();
    fifo_full = force_full || (fifo_q.size() >= DEPTH);
    rd_en = rd_alt ? cyc[0] : 1'b1;
    cyc++;
    #1;
    e_gv    = (m_owner >= 0);
    e_ready = '0;
    e_wen   = 1'b0;
    e_data  = '0;
    if (e_gv) begin
      if (!fifo_full) e_ready[m_owner] = 1'b1;
      e_wen = req_valid[m_owner] && !fifo_full;
      if (e_wen) e_data = rq[m_owner][0];
    end
    chk("grant_valid", int'(grant_valid), int'(e_gv));
    chk("req_ready", int'(req_ready), int'(e_ready));
    chk("fifo_w_en", int'(fifo_w_en), int'(e_wen));
    if (e_gv) chk("grant_id", int'(grant_id), m_owner);
    if (e_wen) chk("fifo_data_in", int'(fifo_data_in), int'(e_data));

    // Grant trace as observed on the DUT
    if (grant_valid && !prev_gv) begin
      if (g_ids.size() > 0) g_gaps.push_back(idle_cnt);
      g_ids.push_back(int'(grant_id));
      g_beats.push_back(0);
    end
    if (grant_valid) idle_cnt = 0;
    else idle_cnt++;
    if (fifo_w_en && g_beats.size() > 0) g_beats[g_beats.size()-1] = g_beats[g_beats.size()-1] + 1;
    prev_gv = grant_valid;

    // Shared FIFO: read takes an existing entry, then this cycle's write lands
    if (rd_en && fifo_q.size() > 0) begin
      got = fifo_q.pop_front();
      if (exp_q.size() == 0) chk("sb_underflow", int'(exp_q.size()), 1);
      else chk("sb_data", int'(got), int'(exp_q.pop_front()));
    end
    if (fifo_w_en) begin
      fifo_q.push_back(fifo_data_in);
      wr_log.push_back(fifo_data_in);
    end
    if (e_wen) exp_q.push_back(e_data);

    // Model update for the coming posedge
    if (!rst_n) begin
      model_reset();
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && req_valid[idx]) begin
          m_owner = idx;
          m_beats = 0;
        end
      end
    end else begin
      if (e_wen) begin
        void'(rq[m_owner].pop_front());
        m_beats++;
      end
      if (!req_valid[m_owner] || m_beats == BL) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_beats = 0;
      end
    end
  endtask

  task automatic reset_seq();
    model_reset();
    clear_env();
    force_full = 1'b0;
    rd_alt     = 1'b0;
    rst_val    = 1'b0;
    cycle();
    chk("rst_grant_valid", int'(grant_valid), 0);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_fifo_w_en", int'(fifo_w_en), 0);
    chk("rst_fifo_data_in", int'(fifo_data_in), 0);
    cycle();
    rst_val = 1'b1;
    clear_logs();
  endtask

  initial begin
    bit drained;
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    rst_n = 1'b0;
    rst_val = 1'b0;
    force_full = 1'b0;
    rd_alt = 1'b0;
    rd_en = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data = '0;
    model_reset();
    clear_env();

    // Single requester with six words: bursts of 4 then 2
    reset_seq();
    for (int k = 0; k < 6; k++) rq[1].push_back(8'(8'h10 + k));
    for (int c = 0; c < 20; c++) cycle();
    chk("t1_ngrants", g_ids.size(), 2);
    if (g_ids.size() == 2) begin
      chk("t1_id0", g_ids[0], 1);
      chk("t1_id1", g_ids[1], 1);
      chk("t1_beats0", g_beats[0], 4);
      chk("t1_beats1", g_beats[1], 2);
      chk("t1_gap", g_gaps[0], 1);
    end
    chk("t1_nwords", wr_log.size(), 6);
    for (int k = 0; k < wr_log.size() && k < 6; k++) chk("t1_word", int'(wr_log[k]), 16 + k);

    // All four continuously valid: round robin 0,1,2,3,0
    reset_seq();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 12; k++) rq[i].push_back(8'($urandom));
    for (int c = 0; c < 26; c++) cycle();
    chk("t2_ngrants", g_ids.size(), 5);
    for (int k = 0; k < 5 && k < g_ids.size(); k++) begin
      chk("t2_id", g_ids[k], k % 4);
      chk("t2_beats", g_beats[k], 4);
    end
    for (int k = 0; k < g_gaps.size(); k++) chk("t2_gap", g_gaps[k], 1);

    // FIFO full for three cycles mid-burst
    reset_seq();
    for (int k = 0; k < 4; k++) rq[0].push_back(8'(8'h30 + k));
    for (int c = 0; c < 14; c++) begin
      force_full = (c >= 3 && c <= 5);
      cycle();
      if (c >= 3 && c <= 5) begin
        chk("t3_full_wen", int'(fifo_w_en), 0);
        chk("t3_full_ready", int'(req_ready), 0);
        chk("t3_full_hold", int'(grant_valid), 1);
      end
    end
    force_full = 1'b0;
    chk("t3_ngrants", g_ids.size(), 1);
    if (g_beats.size() > 0) chk("t3_beats", g_beats[0], 4);
    chk("t3_nwords", wr_log.size(), 4);
    for (int k = 0; k < wr_log.size() && k < 4; k++) chk("t3_word", int'(wr_log[k]), 48 + k);

    // Early release after two beats, next valid requester follows
    reset_seq();
    for (int k = 0; k < 2; k++) rq[0].push_back(8'(8'h40 + k));
    for (int k = 0; k < 3; k++) rq[2].push_back(8'(8'h60 + k));
    for (int c = 0; c < 20; c++) cycle();
    chk("t4_ngrants", g_ids.size(), 2);
    if (g_ids.size() == 2) begin
      chk("t4_id0", g_ids[0], 0);
      chk("t4_id1", g_ids[1], 2);
      chk("t4_beats0", g_beats[0], 2);
      chk("t4_beats1", g_beats[1], 3);
      chk("t4_gap", g_gaps[0], 1);
    end

    // Asynchronous reset between edges in the middle of a burst
    reset_seq();
    for (int k = 0; k < 6; k++) rq[1].push_back(8'(8'h50 + k));
    for (int c = 0; c < 3; c++) cycle();
    @(negedge clk);
    chk("t5_pre_gv", int'(grant_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_gv", int'(grant_valid), 0);
    chk("t5_async_ready", int'(req_ready), 0);
    chk("t5_async_wen", int'(fifo_w_en), 0);
    chk("t5_async_data", int'(fifo_data_in), 0);
    chk("t5_async_id", int'(grant_id), 0);
    model_reset();
    clear_env();
    rst_val = 1'b0;
    cycle();
    rst_val = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rq[2].push_back(8'(8'h70 + k));
      rq[3].push_back(8'(8'h80 + k));
    end
    clear_logs();
    for (int c = 0; c < 12; c++) cycle();
    chk("t5_ngrants", g_ids.size(), 2);
    if (g_ids.size() == 2) begin
      chk("t5_id0", g_ids[0], 2);
      chk("t5_id1", g_ids[1], 3);
    end

    // Randomized rounds with alternating FIFO reads
    for (int r = 0; r < 2; r++) begin
      reset_seq();
      rd_alt = 1'b1;
      for (int c = 0; c < 60; c++) begin
        for (int i = 0; i < N; i++)
          if ($urandom_range(3) == 0 && rq[i].size() < 6) rq[i].push_back(8'($urandom));
        cycle();
      end
      rd_alt = 1'b0;
      drained = 1'b0;
      for (int c = 0; c < 300 && !drained; c++) begin
        cycle();
        drained = (m_owner < 0) && (fifo_q.size() == 0);
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) drained = 1'b0;
      end
      chk("rand_drain_done", int'(drained), 1);
      chk("rand_sb_left", exp_q.size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester data word and of the FIFO write data.
REQ-002 Parameter NUM_REQ, default 4: number of write requesters.
REQ-003 Parameter BURST_LEN, default 4: maximum beats accepted per grant.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 req_valid  input  NUM_REQ  per-requester write request; bit i belongs to requester i.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  requester i data in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 req_ready  output  NUM_REQ  per-requester accept; a beat transfers when valid and ready are both high at posedge.
REQ-009 fifo_full  input  1  full flag from the shared synchronous FIFO.
REQ-010 fifo_w_en  output  1  write enable to the FIFO.
REQ-011 fifo_data_in  output  DATA_WIDTH  write data to the FIFO.
REQ-012 grant_valid  output  1  a requester currently holds the write port.
REQ-013 grant_id  output  clog2(NUM_REQ)  index of the granted requester; meaningful only when grant_valid=1.

Function
REQ-014 State machine has exactly two states: IDLE (no grant) and BURST (grant held).
REQ-015 IDLE: if any req_valid bit is high, the posedge selects the first requester with valid high, searching upward from rr_ptr with wrap from NUM_REQ-1 to 0, loads grant_id, clears beat_cnt, and enters BURST; otherwise stays in IDLE.
REQ-016 IDLE: req_ready=0, fifo_w_en=0, grant_valid=0.
REQ-017 BURST: req_ready[grant_id] = !fifo_full; all other req_ready bits are 0; grant_valid=1.
REQ-018 BURST: fifo_w_en = req_valid[grant_id] & !fifo_full (combinational); fifo_data_in = req_data slice of grant_id.
REQ-019 fifo_w_en is never high while fifo_full=1; no beat is accepted or dropped while full; the grant is held with no timeout.
REQ-020 Each posedge with fifo_w_en=1 increments beat_cnt (width clog2(BURST_LEN+1)).
REQ-021 BURST exits to IDLE at the posedge where the beat being written makes beat_cnt reach BURST_LEN, or at any posedge where req_valid[grant_id]=0.
REQ-022 On exit, rr_ptr <= (grant_id+1) mod NUM_REQ; beat_cnt clears.
REQ-023 Exactly one IDLE cycle separates consecutive grants; maximum sustained throughput is BURST_LEN beats per BURST_LEN+1 cycles.
REQ-024 Requesters hold req_valid and data stable until accepted; a requester that drops valid forfeits the rest of its burst.
REQ-025 Starvation bound: a requester holding valid is granted within NUM_REQ-1 other grants.
REQ-026 Changes on non-granted req_valid lines during BURST have no effect on outputs or state.

Reset
REQ-027 While rst_n=0: state=IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, grant_valid=0, req_ready=0, fifo_w_en=0, fifo_data_in=0.
REQ-028 Reset asserted mid-burst aborts the burst immediately; no further FIFO write occurs until a new grant after rst_n rises.
REQ-029 First arbitration after reset starts the search at requester 0.

Verification
REQ-030 Single requester: req_valid=4'b0010, 6 words queued, FIFO not full -> grant_id=1, writes 4 beats, 1 IDLE cycle, regrant to 1, writes 2 beats; FIFO readback order matches.
REQ-031 Round robin: all 4 valid continuously -> grant order 0,1,2,3,0, each grant exactly 4 beats, grant_valid low for 1 cycle between grants.
REQ-032 Full backpressure: fifo_full=1 for 3 cycles mid-burst -> fifo_w_en=0 and req_ready=0 during those cycles; burst resumes with no lost or duplicated word; beat_cnt still ends at 4.
REQ-033 Early release: granted requester drops valid after 2 beats -> return to IDLE next edge; rr_ptr = grant_id+1; next valid requester granted.
REQ-034 Async reset mid-burst: rst_n low between edges -> all outputs 0 without waiting for clk; after release, requesters 2 and 3 valid -> grant_id=2 first.
REQ-035 Scoreboard: per-requester reference queues checked against FIFO data_out across 2 randomized rounds of 60 cycles with alternating read enable; zero mismatches.
